// File: rtl/aes_pkg.sv
// Shared types, constants and the GF(2^8) helper for the AES round controller.
// Key-schedule timing: rcon_o carries round r's constant during round r (INIT already shows round 1's).
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    localparam int ROUND_W = 4;

    localparam logic [7:0] RCON_INIT_DEF = 8'h01;
    localparam logic [7:0] RCON_POLY     = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reloads to the first constant, steps by xtime per key-schedule round.
module aes_rcon_gen
    import aes_pkg::*;
#(
    parameter logic [7:0] RCON_INIT = RCON_INIT_DEF
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] rcon
);

    // load wins so an abort in mid-block always restores the first constant
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rcon <= RCON_INIT;
        else if (load)
            rcon <= RCON_INIT;
        else if (advance)
            rcon <= xtime(rcon);
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: INIT load, NR-1 full rounds, a final round without MixColumns, then a done pulse.
// Every output is a register, so no input reaches an output in the same cycle.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int         NR        = NR_128,
    parameter logic [7:0] RCON_INIT = RCON_INIT_DEF
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               st_ld_o,
    output logic               st_en_o,
    output logic               ks_ld_o,
    output logic               ks_en_o,
    output logic               last_o,
    output logic [ROUND_W-1:0] round_o,
    output logic [7:0]         rcon_o,
    output logic               done_o,
    output logic               drop_o
);

    if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_nr_check
        $error("aes_round_ctrl: NR must be 10, 12 or 14");
    end

    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NR - 1);
    localparam logic [ROUND_W-1:0] ROUND_MAX  = ROUND_W'(NR);

    state_t state;
    state_t state_nxt;
    logic   rcon_load;

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = (ld_i && !abort_i) ? ST_INIT : ST_IDLE;
            ST_INIT:  state_nxt = abort_i ? ST_IDLE : ST_ROUND;
            ST_ROUND: begin
                if (abort_i)
                    state_nxt = ST_IDLE;
                else if (round_o == ROUND_LAST)
                    state_nxt = ST_FINAL;
                else
                    state_nxt = ST_ROUND;
            end
            ST_FINAL: state_nxt = abort_i ? ST_IDLE : ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy_o  <= 1'b0;
            st_ld_o <= 1'b0;
            st_en_o <= 1'b0;
            ks_ld_o <= 1'b0;
            ks_en_o <= 1'b0;
            last_o  <= 1'b0;
            done_o  <= 1'b0;
            drop_o  <= 1'b0;
            round_o <= '0;
        end else begin
            state   <= state_nxt;
            busy_o  <= (state_nxt != ST_IDLE);
            st_ld_o <= (state_nxt == ST_INIT);
            ks_ld_o <= (state_nxt == ST_INIT);
            st_en_o <= (state_nxt == ST_ROUND) || (state_nxt == ST_FINAL);
            ks_en_o <= (state_nxt == ST_ROUND) || (state_nxt == ST_FINAL);
            last_o  <= (state_nxt == ST_FINAL);
            done_o  <= (state_nxt == ST_DONE);
            // requests arriving in any busy state, DONE included, are dropped rather than queued
            drop_o  <= ld_i && (state != ST_IDLE);
            if (state_nxt == ST_IDLE || state_nxt == ST_INIT)
                round_o <= '0;
            else if (round_o != ROUND_MAX)
                round_o <= round_o + ROUND_W'(1);
        end
    end

    assign rcon_load = abort_i || (state == ST_IDLE) || (state == ST_DONE);

    aes_rcon_gen #(
        .RCON_INIT (RCON_INIT)
    ) u_rcon_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (rcon_load),
        .advance (ks_en_o),
        .rcon    (rcon_o)
    );

endmodule
